// File: rtl/cu_pkg.sv
// Shared control-unit definitions: 13-bit instruction layout, loader FSM states
// and the field packer used by both the loader and the decode model.
package cu_pkg;

    localparam int INST_W = 13;

    localparam logic [3:0] OP_LD = 4'b1110;
    localparam logic [3:0] OP_ST = 4'b1111;

    localparam int OPCODE_LSB = 9;
    localparam int OPA_LSB    = 6;
    localparam int OPB_LSB    = 3;
    localparam int DMADDR_LSB = 5;
    localparam int DEST_LSB   = 0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_FLUSH,
        ST_DONE
    } enc_state_t;

    // Memory ops carry a data address where R-types carry two source registers.
    function automatic logic [INST_W-1:0] encode(
        input logic [3:0] opcode,
        input logic [2:0] opa,
        input logic [2:0] opb,
        input logic [2:0] dst,
        input logic [3:0] dmaddr
    );
        logic [INST_W-1:0] word;
        word = '0;
        word[OPCODE_LSB +: 4] = opcode;
        if (opcode == OP_LD || opcode == OP_ST) begin
            word[DMADDR_LSB +: 4] = dmaddr;
        end else begin
            word[OPA_LSB +: 3] = opa;
            word[OPB_LSB +: 3] = opb;
        end
        word[DEST_LSB +: 3] = dst;
        return word;
    endfunction

endpackage

// File: rtl/inst_fifo.sv
// Synchronous FIFO for encoded instruction words; head is readable
// combinationally and reads as zero while the FIFO is empty.
module inst_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 13
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_wdata,
    output logic [WIDTH-1:0] o_head,
    output logic             o_full,
    output logic             o_empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wrPtr;
    logic [AW:0]      r_rdPtr;
    logic             w_doPush;
    logic             w_doPop;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign o_empty  = (r_wrPtr == r_rdPtr);
    assign o_full   = (r_wrPtr[AW] != r_rdPtr[AW]) && (r_wrPtr[AW-1:0] == r_rdPtr[AW-1:0]);
    assign w_doPush = i_push && !o_full;
    assign w_doPop  = i_pop && !o_empty;
    assign o_head   = o_empty ? '0 : r_mem[r_rdPtr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
        end else begin
            if (w_doPush) r_wrPtr <= r_wrPtr + (AW+1)'(1);
            if (w_doPop)  r_rdPtr <= r_rdPtr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_doPush) r_mem[r_wrPtr[AW-1:0]] <= i_wdata;
    end

endmodule

// File: rtl/inst_encoder.sv
// Instruction loader: packs field-level requests into 13-bit words and streams
// them into instruction memory from address 0. Overflow guard: INST_ENC_OVF_ERR_EN.
module inst_encoder
    import cu_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int IMEM_AW    = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                in_last,
    input  logic [3:0]          opcode,
    input  logic [2:0]          operanda,
    input  logic [2:0]          operandb,
    input  logic [2:0]          dest,
    input  logic [3:0]          dmaddr,
    output logic                im_we,
    input  logic                im_ready,
    output logic [IMEM_AW-1:0]  im_addr,
    output logic [INST_W-1:0]   im_wdata,
    output logic                busy,
    output logic                done,
    output logic [IMEM_AW:0]    count,
    output logic                err
);

    enc_state_t         r_state;
    logic [IMEM_AW-1:0] r_addr;
    logic [IMEM_AW:0]   r_count;
    logic [INST_W-1:0]  w_word;
    logic [INST_W-1:0]  w_head;
    logic               w_full;
    logic               w_empty;
    logic               w_push;
    logic               w_pop;
    logic               w_active;
    logic               w_block;
    logic               w_wr;

    assign w_word   = encode(opcode, operanda, operandb, dest, dmaddr);
    assign w_active = (r_state == ST_LOAD) || (r_state == ST_FLUSH);
    assign in_ready = (r_state == ST_LOAD) && !w_full;
    assign w_push   = in_valid && in_ready;

`ifdef INST_ENC_OVF_ERR_EN
    localparam logic [IMEM_AW:0] CNT_LIMIT = (IMEM_AW+1)'(2**IMEM_AW);
    logic r_err;
    // Once memory is full, remaining words are drained without being written.
    assign w_block = w_active && !w_empty && (r_count == CNT_LIMIT);
    assign err     = r_err;
`else
    assign w_block = 1'b0;
    assign err     = 1'b0;
`endif

    assign im_we    = w_active && !w_empty && !w_block;
    assign w_wr     = im_we && im_ready;
    assign w_pop    = w_wr || w_block;
    assign im_addr  = r_addr;
    assign im_wdata = w_head;
    assign count    = r_count;
    assign busy     = (r_state != ST_IDLE);
    assign done     = (r_state == ST_DONE);

    inst_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (INST_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_wdata (w_word),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // Writes only occur in LOAD/FLUSH, so they never collide with the start clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_addr  <= '0;
            r_count <= '0;
`ifdef INST_ENC_OVF_ERR_EN
            r_err   <= 1'b0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_addr  <= '0;
                        r_count <= '0;
`ifdef INST_ENC_OVF_ERR_EN
                        r_err   <= 1'b0;
`endif
                        r_state <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (w_push && in_last) r_state <= ST_FLUSH;
                end
                ST_FLUSH: begin
                    if (w_empty) r_state <= ST_DONE;
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
            if (w_wr) begin
                r_addr  <= r_addr + IMEM_AW'(1);
                r_count <= r_count + (IMEM_AW+1)'(1);
            end
`ifdef INST_ENC_OVF_ERR_EN
            if (w_block) r_err <= 1'b1;
`endif
        end
    end

endmodule

// File: tb/tb_inst_encoder.sv
// Self-checking bench for inst_encoder: a queue-based loader model checked every
// cycle, plus directed loads with hand-computed words and addresses.
module tb_inst_encoder;

    localparam int FIFO_DEPTH = 4;
    localparam int IMEM_AW    = 4;
    localparam int MEM_WORDS  = 16;
`ifdef INST_ENC_OVF_ERR_EN
    localparam bit OVF_EN = 1'b1;
`else
    localparam bit OVF_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        in_valid;
    logic        in_ready;
    logic        in_last;
    logic [3:0]  opcode;
    logic [2:0]  operanda;
    logic [2:0]  operandb;
    logic [2:0]  dest;
    logic [3:0]  dmaddr;
    logic        im_we;
    logic        im_ready;
    logic [3:0]  im_addr;
    logic [12:0] im_wdata;
    logic        busy;
    logic        done;
    logic [4:0]  count;
    logic        err;

    int testsRun    = 0;
    int testsFailed = 0;

    bit          monEn = 1'b0;
    bit          mActive = 1'b0;
    bit          mLastAcc = 1'b0;
    bit          mErr = 1'b0;
    int          mCd = 0;
    int          mAddr = 0;
    int          mCount = 0;
    logic [12:0] mQ[$];
    int          wrAddr[$];
    logic [12:0] wrData[$];

    inst_encoder #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .IMEM_AW    (IMEM_AW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_last  (in_last),
        .opcode   (opcode),
        .operanda (operanda),
        .operandb (operandb),
        .dest     (dest),
        .dmaddr   (dmaddr),
        .im_we    (im_we),
        .im_ready (im_ready),
        .im_addr  (im_addr),
        .im_wdata (im_wdata),
        .busy     (busy),
        .done     (done),
        .count    (count),
        .err      (err)
    );

    always #5 clk = ~clk;

    function automatic logic [12:0] modelEncode(input logic [3:0] op, input logic [2:0] a,
                                                input logic [2:0] b, input logic [2:0] d,
                                                input logic [3:0] dm);
        if (op >= 4'd14) return {op, dm, 2'b00, d};
        return {op, a, b, d};
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
        testsRun++;
        if (got !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    // Model predicts this cycle's outputs, then advances using the inputs the next edge will see.
    always @(negedge clk) begin : monitor
        bit          expRdy;
        bit          expWe;
        bit          blk;
        bit          wasActive;
        bit          popped;
        logic [12:0] expData;
        blk     = OVF_EN && mActive && (mQ.size() > 0) && (mCount == MEM_WORDS);
        expWe   = mActive && (mQ.size() > 0) && !blk;
        expRdy  = mActive && !mLastAcc && (mQ.size() < FIFO_DEPTH);
        expData = (mQ.size() > 0) ? mQ[0] : 13'h0;
        if (monEn) begin
            checkOutput("mon_in_ready", in_ready, expRdy);
            checkOutput("mon_im_we", im_we, expWe);
            checkOutput("mon_im_addr", im_addr, mAddr);
            checkOutput("mon_im_wdata", im_wdata, expData);
            checkOutput("mon_busy", busy, mActive);
            checkOutput("mon_done", done, (mCd == 1));
            checkOutput("mon_count", count, mCount % 32);
            checkOutput("mon_err", err, mErr);
        end
        if (im_we === 1'b1 && im_ready === 1'b1) begin
            wrAddr.push_back(int'(im_addr));
            wrData.push_back(im_wdata);
        end
        if (rst) begin
            mActive = 0; mLastAcc = 0; mErr = 0; mCd = 0; mAddr = 0; mCount = 0;
            mQ.delete();
        end else begin
            wasActive = mActive;
            popped    = 0;
            if (mCd == 1) begin
                mCd = 0;
                mActive = 0;
            end else if (mCd == 2) begin
                mCd = 1;
            end
            if (blk) begin
                void'(mQ.pop_front());
                mErr = 1;
                popped = 1;
            end else if (expWe && im_ready) begin
                void'(mQ.pop_front());
                mAddr = (mAddr + 1) % MEM_WORDS;
                mCount++;
                popped = 1;
            end
            if (expRdy && in_valid) begin
                mQ.push_back(modelEncode(opcode, operanda, operandb, dest, dmaddr));
                if (in_last) mLastAcc = 1;
            end
            if (popped && mQ.size() == 0 && mLastAcc) mCd = 2;
            if (!wasActive && start) begin
                mActive = 1; mAddr = 0; mCount = 0; mErr = 0; mLastAcc = 0;
            end
        end
    end

    task automatic syncUp();
        @(posedge clk);
        #1;
    endtask

    task automatic pulseStart();
        start = 1'b1;
        syncUp();
        start = 1'b0;
    endtask

    task automatic applyStimulus(input logic [3:0] op, input logic [2:0] a, input logic [2:0] b,
                                 input logic [2:0] d, input logic [3:0] dm, input logic last);
        bit accepted;
        accepted = 0;
        opcode = op; operanda = a; operandb = b; dest = d; dmaddr = dm;
        in_last = last; in_valid = 1'b1;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (in_ready === 1'b1) begin
                accepted = 1;
                break;
            end
        end
        if (!accepted) checkOutput("req_accept_timeout", 0, 1);
        syncUp();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic waitDone();
        bit seen;
        seen = 0;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                seen = 1;
                break;
            end
        end
        checkOutput("done_seen", seen, 1);
    endtask

    task automatic checkWrite(input string name, input int idx, input int expAddr, input logic [12:0] expData);
        if (wrAddr.size() > idx) begin
            checkOutput({name, "_addr"}, wrAddr[idx], expAddr);
            checkOutput({name, "_data"}, wrData[idx], expData);
        end else begin
            checkOutput({name, "_missing"}, wrAddr.size(), idx + 1);
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_last = 1'b0;
        opcode = '0; operanda = '0; operandb = '0; dest = '0; dmaddr = '0;
        im_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_in_ready", in_ready, 0);
        checkOutput("rst_im_we", im_we, 0);
        checkOutput("rst_im_addr", im_addr, 0);
        checkOutput("rst_im_wdata", im_wdata, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_count", count, 0);
        checkOutput("rst_err", err, 0);
        syncUp();
        rst = 1'b0;
        monEn = 1'b1;

        // Single R-type word.
        pulseStart();
        wrAddr.delete(); wrData.delete();
        applyStimulus(4'b0001, 3'b001, 3'b010, 3'b011, 4'h0, 1'b1);
        waitDone();
        checkWrite("single", 0, 0, 13'h0253);
        @(negedge clk);
        checkOutput("single_count", count, 1);
        checkOutput("single_done_pulse", done, 0);
        checkOutput("single_busy_after", busy, 0);
        syncUp();

        // M-type words; operand fields must be ignored.
        pulseStart();
        wrAddr.delete(); wrData.delete();
        applyStimulus(4'b1111, 3'b000, 3'b000, 3'b101, 4'b1100, 1'b0);
        applyStimulus(4'b1110, 3'b111, 3'b111, 3'b100, 4'b0100, 1'b1);
        waitDone();
        checkWrite("mtype0", 0, 0, 13'h1F85);
        checkWrite("mtype1", 1, 1, 13'h1C84);
        syncUp();

        // Backpressure fills the FIFO, then drains five words in order.
        im_ready = 1'b0;
        pulseStart();
        wrAddr.delete(); wrData.delete();
        applyStimulus(4'b0001, 3'b001, 3'b010, 3'b011, 4'h0, 1'b0);
        applyStimulus(4'b0010, 3'b011, 3'b100, 3'b101, 4'h0, 1'b0);
        applyStimulus(4'b0011, 3'b110, 3'b000, 3'b001, 4'h0, 1'b0);
        applyStimulus(4'b0100, 3'b010, 3'b010, 3'b010, 4'h0, 1'b0);
        fork
            applyStimulus(4'b0101, 3'b101, 3'b110, 3'b111, 4'h0, 1'b1);
            begin
                repeat (3) @(negedge clk);
                checkOutput("bp_in_ready", in_ready, 0);
                checkOutput("bp_im_we", im_we, 1);
                checkOutput("bp_im_wdata", im_wdata, 13'h0253);
                checkOutput("bp_im_addr", im_addr, 0);
                syncUp();
                im_ready = 1'b1;
            end
        join
        waitDone();
        checkOutput("bp_writes", wrAddr.size(), 5);
        for (int i = 0; i < 5 && i < wrAddr.size(); i++) checkOutput("bp_seq_addr", wrAddr[i], i);
        checkWrite("bp_first", 0, 0, 13'h0253);
        checkWrite("bp_fifth", 4, 4, 13'h0B77);
        syncUp();

        // Seventeen words into a sixteen-word memory.
        pulseStart();
        wrAddr.delete(); wrData.delete();
        for (int i = 0; i < 17; i++)
            applyStimulus(4'(i % 14), 3'(i), 3'(i + 1), 3'(i + 2), 4'h0, (i == 16));
        waitDone();
`ifdef INST_ENC_OVF_ERR_EN
        checkOutput("ovf_writes", wrAddr.size(), 16);
        checkOutput("ovf_count", count, 16);
        checkOutput("ovf_err", err, 1);
`else
        checkOutput("wrap_writes", wrAddr.size(), 17);
        checkOutput("wrap_count", count, 17);
        checkOutput("wrap_err", err, 0);
        checkWrite("wrap_17th", 16, 0, 13'h040A);
`endif
        syncUp();

        // Reset during FLUSH with three words buffered.
        im_ready = 1'b0;
        pulseStart();
        applyStimulus(4'b0001, 3'b001, 3'b001, 3'b001, 4'h0, 1'b0);
        applyStimulus(4'b0010, 3'b010, 3'b010, 3'b010, 4'h0, 1'b0);
        applyStimulus(4'b0011, 3'b011, 3'b011, 3'b011, 4'h0, 1'b1);
        @(negedge clk);
        checkOutput("flush_busy", busy, 1);
        checkOutput("flush_in_ready", in_ready, 0);
        syncUp();
        rst = 1'b1;
        syncUp();
        rst = 1'b0;
        @(negedge clk);
        checkOutput("abort_im_we", im_we, 0);
        checkOutput("abort_busy", busy, 0);
        checkOutput("abort_count", count, 0);
        im_ready = 1'b1;
        syncUp();
        pulseStart();
        wrAddr.delete(); wrData.delete();
        applyStimulus(4'b0001, 3'b001, 3'b010, 3'b011, 4'h0, 1'b1);
        waitDone();
        checkOutput("abort_reload_writes", wrAddr.size(), 1);
        checkWrite("abort_reload", 0, 0, 13'h0253);
        syncUp();

        // start during LOAD must not restart the address sequence.
        pulseStart();
        wrAddr.delete(); wrData.delete();
        applyStimulus(4'b0110, 3'b001, 3'b001, 3'b001, 4'h0, 1'b0);
        start = 1'b1;
        applyStimulus(4'b0111, 3'b010, 3'b010, 3'b010, 4'h0, 1'b0);
        start = 1'b0;
        applyStimulus(4'b1000, 3'b011, 3'b011, 3'b011, 4'h0, 1'b1);
        waitDone();
        checkOutput("restart_writes", wrAddr.size(), 3);
        for (int i = 0; i < 3 && i < wrAddr.size(); i++) checkOutput("restart_addr", wrAddr[i], i);
        syncUp();

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/inst_encoder.md
# inst_encoder

Instruction encoder/loader: the write side of the control unit's 13-bit instruction format. It accepts field-level instruction requests over a valid/ready handshake and packs them into 13-bit words. Words are buffered in a small FIFO and streamed into instruction memory at consecutive addresses starting from 0. It sits between the test/boot host and instruction memory, producing exactly the words the control unit decodes.

## Interface
Parameters:
- FIFO_DEPTH, 4, encoded-word buffer entries (power of two, ≥2)
- IMEM_AW, 4, instruction-memory address width (2^IMEM_AW words)

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  clock, rising edge
- rst  in  1  synchronous active-high reset
- start  in  1  one-cycle pulse: begin a program load at address 0
- in_valid  in  1  request valid
- in_ready  out  1  request accepted when in_valid && in_ready
- in_last  in  1  final instruction of the program
- opcode  in  4  instruction opcode
- operanda  in  3  R-type source A
- operandb  in  3  R-type source B
- dest  in  3  destination register
- dmaddr  in  4  M-type data-memory address
- im_we  out  1  instruction-memory write valid
- im_ready  in  1  memory accepts the write when im_we && im_ready
- im_addr  out  IMEM_AW  write address
- im_wdata  out  13  encoded instruction
- busy  out  1  load in progress
- done  out  1  one-cycle pulse when the last word is written
- count  out  IMEM_AW+1  words written in the current load
- err  out  1  sticky overflow flag (present only with the macro; tied 0 otherwise)

## Operation
- Encoding, R-type (opcode not 4'b1110/4'b1111): [12:9]=opcode, [8:6]=operanda, [5:3]=operandb, [2:0]=dest.
- Encoding, M-type (opcode 4'b1110 load, 4'b1111 store): [12:9]=opcode, [8:5]=dmaddr, [4:3]=2'b00, [2:0]=dest. Operanda/operandb ignored.
- The encoding is combinational on the request fields. The encoded word is pushed into the FIFO on acceptance.
- FSM states:
  - IDLE: waits for start. start clears the address and count registers and goes to LOAD.
  - LOAD: accepts requests. Accepting with in_last=1 goes to FLUSH.
  - FLUSH: in_ready=0. Goes to DONE when the FIFO is empty.
  - DONE: done=1 for one cycle, then IDLE.
- start outside IDLE is ignored.
- in_ready = (state==LOAD) && !fifo_full. There is no bypass: a full FIFO with a simultaneous pop still deasserts in_ready.
- im_we = (state∈{LOAD,FLUSH}) && !fifo_empty. im_wdata is the FIFO head and im_addr is the address register.
- On each write handshake: pop the FIFO, address+1, count+1.
- Writes do not depend on in_valid. Simultaneous push and pop leaves occupancy unchanged.
- busy = state≠IDLE.
- Address wrap at 2^IMEM_AW writes: see Configuration.

## Timing
- Reset values: state IDLE, FIFO empty, in_ready 0, im_we 0, im_addr 0, im_wdata 0 (empty head reads 0), busy 0, done 0, count 0, err 0.
- A request accepted at edge N appears on im_we/im_wdata in cycle N+1. Throughput is 1 word/cycle when im_ready=1.
- im_ready=0 holds im_we, im_addr and im_wdata stable until the handshake.
- done rises one cycle after the edge that writes the last word.
- rst mid-load aborts immediately. The FIFO is emptied; buffered words are discarded, not written.
- in_last on a request that is not accepted has no effect.

## Configuration
- INST_ENC_OVF_ERR_EN defined:
  - A write handshake when count==2^IMEM_AW is blocked: im_we is forced 0, and the word is popped and dropped.
  - err sets and stays set until the next start or rst.
  - The load still reaches DONE.
- INST_ENC_OVF_ERR_EN undefined:
  - im_addr wraps from 2^IMEM_AW-1 to 0 and overwrites silently.
  - err is constant 0.

## Structure
- Package cu_pkg holds:
  - INST_W=13
  - OP_LD=4'b1110, OP_ST=4'b1111
  - field bit-position localparams
  - the state enum typedef
  - an encode function shared with the control unit's decode model
- One sub-module, inst_fifo: synchronous FIFO with parameterised depth, push/pop, full/empty, combinational head read.

## Test plan
- start; one request opcode=0001, a=001, b=010, dest=011, in_last=1 → im_we with im_addr 0, im_wdata 13'h0253; then done pulse; count=1.
- Requests {1111, dmaddr=1100, dest=101} then {1110, dmaddr=0100, dest=100, a=111, b=111}, im_ready=1 → writes 13'h1F85 @0, 13'h1C84 @1 (operands ignored).
- Hold im_ready=0 while issuing 5 requests with FIFO_DEPTH=4 → in_ready drops after 4 accepts; im_wdata stays 13'h0253; release → 5 sequential writes at addresses 0–4.
- Load 17 words with IMEM_AW=4:
  - with the macro, the 17th word is not written, err=1, done pulses;
  - without the macro, the 17th word is written at address 0.
- Assert rst during FLUSH with 3 words buffered → next cycle im_we=0, busy=0, count=0; a following start loads from address 0.
- start pulsed during LOAD → ignored; address sequence continues unbroken.
